// File: rtl/uart_rx_cmd_decoder.sv
// Command frame decoder behind the UART receive core: assembles SYNC/ADDR/DATA_H/DATA_L/CSUM
// frames, validates them and issues one-cycle register write/read strobes.
module uart_rx_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        iDE,
  input  logic [7:0]  iDATA,
  input  logic        iPARITY_ERROR,
  input  logic        iRETRY,
  input  logic        iCLEAR_ERR,
  output logic        oWE,
  output logic        oRE,
  output logic [6:0]  oADDR,
  output logic [15:0] oWDATA,
  output logic        oFRAME_ERR,
  output logic [7:0]  oERR_COUNT
);

  // state   | meaning
  // ST_HUNT | idle, waiting for SYNC_BYTE
  // ST_ADDR | expecting R/nW + address byte
  // ST_DATH | expecting DATA_H
  // ST_DATL | expecting DATA_L
  // ST_CSUM | expecting checksum byte
  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_DATH,
    ST_DATL,
    ST_CSUM
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

  state_t                   state, state_nxt;
  logic [7:0]               acc;
  logic [7:0]               addr_q;
  logic [7:0]               dath_q;
  logic [7:0]               datl_q;
  logic [TIMEOUT_WIDTH-1:0] to_cnt;

  logic       good_byte;
  logic       bad_byte;
  logic       timeout_hit;
  logic [7:0] csum_sum;
  logic       accept;
  logic       abort;

  assign good_byte = iDE & ~iPARITY_ERROR & ~iRETRY;
  assign bad_byte  = (iDE & iPARITY_ERROR) | iRETRY;
  assign csum_sum  = acc + iDATA;

  // Timeout fires on the idle cycle that would take the counter to TIMEOUT_CYCLES;
  // a byte in that same cycle wins because the term requires iDE=0.
  assign timeout_hit = TO_EN && (state != ST_HUNT) && !iDE && (to_cnt == TO_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    abort     = 1'b0;
    if (state == ST_HUNT) begin
      if (good_byte && (iDATA == SYNC_BYTE)) state_nxt = ST_ADDR;
    end else if (bad_byte || timeout_hit) begin
      abort     = 1'b1;
      state_nxt = ST_HUNT;
    end else if (good_byte) begin
      case (state)
        ST_ADDR: state_nxt = ST_DATH;
        ST_DATH: state_nxt = ST_DATL;
        ST_DATL: state_nxt = ST_CSUM;
        ST_CSUM: begin
          state_nxt = ST_HUNT;
          if (csum_sum == 8'h00) accept = 1'b1;
          else                   abort  = 1'b1;
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc    <= 8'h00;
      addr_q <= 8'h00;
      dath_q <= 8'h00;
      datl_q <= 8'h00;
    end else if (good_byte && !timeout_hit) begin
      case (state)
        ST_ADDR: begin
          addr_q <= iDATA;
          acc    <= iDATA;
        end
        ST_DATH: begin
          dath_q <= iDATA;
          acc    <= csum_sum;
        end
        ST_DATL: begin
          datl_q <= iDATA;
          acc    <= csum_sum;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                          to_cnt <= '0;
    else if (iDE || (state == ST_HUNT))  to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      oWE        <= 1'b0;
      oRE        <= 1'b0;
      oADDR      <= 7'h00;
      oWDATA     <= 16'h0000;
      oFRAME_ERR <= 1'b0;
    end else begin
      oWE        <= accept & ~addr_q[7];
      oRE        <= accept &  addr_q[7];
      oFRAME_ERR <= abort;
      if (accept) begin
        oADDR  <= addr_q[6:0];
        oWDATA <= {dath_q, datl_q};
      end
    end
  end

  // A clear coinciding with an abort leaves exactly that one abort counted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                             oERR_COUNT <= 8'h00;
    else if (iCLEAR_ERR)                    oERR_COUNT <= abort ? 8'h01 : 8'h00;
    else if (abort && oERR_COUNT != 8'hFF)  oERR_COUNT <= oERR_COUNT + 8'h01;
  end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Directed bench for uart_rx_cmd_decoder with a short timeout so the
// inter-byte abort can be exercised in a few cycles.
module tb_uart_rx_cmd_decoder;

  logic        CLK;
  logic        RST_N;
  logic        iDE;
  logic [7:0]  iDATA;
  logic        iPARITY_ERROR;
  logic        iRETRY;
  logic        iCLEAR_ERR;
  logic        oWE;
  logic        oRE;
  logic [6:0]  oADDR;
  logic [15:0] oWDATA;
  logic        oFRAME_ERR;
  logic [7:0]  oERR_COUNT;

  int checks = 0;
  int errors = 0;

  uart_rx_cmd_decoder #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_WIDTH  (16)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .iDE           (iDE),
    .iDATA         (iDATA),
    .iPARITY_ERROR (iPARITY_ERROR),
    .iRETRY        (iRETRY),
    .iCLEAR_ERR    (iCLEAR_ERR),
    .oWE           (oWE),
    .oRE           (oRE),
    .oADDR         (oADDR),
    .oWDATA        (oWDATA),
    .oFRAME_ERR    (oFRAME_ERR),
    .oERR_COUNT    (oERR_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present one byte for exactly one clock; returns 1 time unit after the sampling edge.
  task automatic send(input logic [7:0] b, input logic par, input logic clr);
    iDE           = 1'b1;
    iDATA         = b;
    iPARITY_ERROR = par;
    iCLEAR_ERR    = clr;
    tick(1);
    iDE           = 1'b0;
    iPARITY_ERROR = 1'b0;
    iCLEAR_ERR    = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                       input logic [7:0] c);
    send(8'hA5, 1'b0, 1'b0);
    send(a, 1'b0, 1'b0);
    send(h, 1'b0, 1'b0);
    send(l, 1'b0, 1'b0);
    send(c, 1'b0, 1'b0);
  endtask

  task automatic chk_outs(input string tag, input logic we, input logic re, input logic [6:0] addr,
                          input logic [15:0] wdata, input logic ferr, input logic [7:0] cnt);
    chk({tag, ".we"},    32'(oWE),        32'(we));
    chk({tag, ".re"},    32'(oRE),        32'(re));
    chk({tag, ".addr"},  32'(oADDR),      32'(addr));
    chk({tag, ".wdata"}, 32'(oWDATA),     32'(wdata));
    chk({tag, ".ferr"},  32'(oFRAME_ERR), 32'(ferr));
    chk({tag, ".cnt"},   32'(oERR_COUNT), 32'(cnt));
  endtask

  initial begin
    RST_N = 1'b0; iDE = 1'b0; iDATA = 8'h00; iPARITY_ERROR = 1'b0;
    iRETRY = 1'b0; iCLEAR_ERR = 1'b0;
    tick(2);
    chk_outs("reset", 1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 8'd0);
    RST_N = 1'b1;
    tick(1);

    frame(8'h12, 8'h34, 8'h56, 8'h64);
    chk_outs("wr", 1'b1, 1'b0, 7'h12, 16'h3456, 1'b0, 8'd0);
    tick(1);
    chk_outs("wr_after", 1'b0, 1'b0, 7'h12, 16'h3456, 1'b0, 8'd0);

    frame(8'h85, 8'h00, 8'h00, 8'h7B);
    chk_outs("rd", 1'b0, 1'b1, 7'h05, 16'h0000, 1'b0, 8'd0);
    tick(1);
    chk("rd_after.re", 32'(oRE), 32'd0);

    frame(8'h12, 8'h34, 8'h56, 8'h65);
    chk_outs("csum_bad", 1'b0, 1'b0, 7'h05, 16'h0000, 1'b1, 8'd1);
    tick(1);
    chk("csum_bad_after.ferr", 32'(oFRAME_ERR), 32'd0);
    // Back-to-back frames: second SYNC immediately follows the first CSUM.
    frame(8'h01, 8'h02, 8'h03, 8'hFA);
    chk_outs("wr2", 1'b1, 1'b0, 7'h01, 16'h0203, 1'b0, 8'd1);
    frame(8'h7F, 8'hFF, 8'hFF, 8'h83);
    chk_outs("wr_b2b", 1'b1, 1'b0, 7'h7F, 16'hFFFF, 1'b0, 8'd1);

    send(8'hA5, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    chk_outs("parity", 1'b0, 1'b0, 7'h7F, 16'hFFFF, 1'b1, 8'd2);
    tick(1);
    iRETRY = 1'b1;
    tick(1);
    iRETRY = 1'b0;
    tick(1);
    chk("retry_hunt.ferr", 32'(oFRAME_ERR), 32'd0);
    chk("retry_hunt.cnt",  32'(oERR_COUNT), 32'd2);

    send(8'hA5, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    iRETRY = 1'b1;
    tick(1);
    iRETRY = 1'b0;
    chk("retry_frame.ferr", 32'(oFRAME_ERR), 32'd1);
    chk("retry_frame.cnt",  32'(oERR_COUNT), 32'd3);

    // Mid-frame SYNC is data: addr byte A5 -> read of 7'h25.
    frame(8'hA5, 8'h00, 8'h00, 8'h5B);
    chk_outs("sync_data", 1'b0, 1'b1, 7'h25, 16'h0000, 1'b0, 8'd3);

    send(8'hA5, 1'b0, 1'b0);
    tick(7);
    chk("to_early.ferr", 32'(oFRAME_ERR), 32'd0);
    tick(1);
    chk("to_fire.ferr", 32'(oFRAME_ERR), 32'd1);
    chk("to_fire.cnt",  32'(oERR_COUNT), 32'd4);
    tick(1);

    send(8'hA5, 1'b0, 1'b0);
    tick(7);
    send(8'h12, 1'b0, 1'b0);
    chk("to_edge.ferr", 32'(oFRAME_ERR), 32'd0);
    send(8'h34, 1'b0, 1'b0);
    send(8'h56, 1'b0, 1'b0);
    send(8'h64, 1'b0, 1'b0);
    chk_outs("to_edge_frame", 1'b1, 1'b0, 7'h12, 16'h3456, 1'b0, 8'd4);

    for (int i = 0; i < 300; i++) begin
      send(8'hA5, 1'b0, 1'b0);
      send(8'h00, 1'b1, 1'b0);
    end
    chk("sat.cnt",  32'(oERR_COUNT), 32'd255);
    chk("sat.ferr", 32'(oFRAME_ERR), 32'd1);

    send(8'hA5, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b1);
    chk("clr_abort.cnt",  32'(oERR_COUNT), 32'd1);
    chk("clr_abort.ferr", 32'(oFRAME_ERR), 32'd1);
    iCLEAR_ERR = 1'b1;
    tick(1);
    iCLEAR_ERR = 1'b0;
    chk("clr.cnt", 32'(oERR_COUNT), 32'd0);

    send(8'hA5, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    chk_outs("mid_reset", 1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 8'd0);
    tick(1);
    RST_N = 1'b1;
    tick(1);
    frame(8'h01, 8'h02, 8'h03, 8'hFA);
    chk_outs("post_reset", 1'b1, 1'b0, 7'h01, 16'h0203, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_decoder.md
Name: uart_rx_cmd_decoder

Overview:
- Sits directly downstream of the UART receive core and consumes its byte strobe, byte data and error flags.
- Assembles fixed 5-byte command frames: SYNC, ADDR, DATA_H, DATA_L, CSUM.
- Checks each frame for integrity and issues single-cycle register write or read requests to the EyeTracker control register bank.
- Aborts partial frames on line errors, checksum mismatch or inter-byte timeout, and counts those aborts.

Parameters:
- SYNC_BYTE, 8'hA5, value that opens a frame.
- TIMEOUT_CYCLES, 50000, CLK cycles allowed between bytes inside a frame; 0 disables the timeout.
- TIMEOUT_WIDTH, 16, width of the inter-byte timeout counter; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_WIDTH.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- iDE  in  1  one-cycle byte-valid strobe from the receive core
- iDATA  in  8  received byte; valid when iDE=1
- iPARITY_ERROR  in  1  parity error of the current byte; sampled only when iDE=1
- iRETRY  in  1  line error; any cycle with iRETRY=1 is a line-error event
- iCLEAR_ERR  in  1  synchronous clear of oERR_COUNT
- oWE  out  1  one-cycle register write strobe
- oRE  out  1  one-cycle register read strobe
- oADDR  out  7  register address
- oWDATA  out  16  write data {DATA_H, DATA_L}
- oFRAME_ERR  out  1  one-cycle pulse when a frame is aborted
- oERR_COUNT  out  8  saturating count of aborted frames

Behaviour:
- Reset (async, RST_N=0): state=HUNT, timeout counter=0, accumulators=0; all outputs 0.
- A byte is "good" when iDE=1, iPARITY_ERROR=0 and iRETRY=0.
- A byte is "bad" when iDE=1 and iPARITY_ERROR=1, or when iRETRY=1 in any cycle. When iDE and iRETRY coincide, the byte is bad.
- States: HUNT, ADDR, DATH, DATL, CSUM.
- HUNT:
  - Good byte equal to SYNC_BYTE -> ADDR.
  - Any other byte (good or bad), or iRETRY -> stay in HUNT; no error pulse, no count.
- ADDR: good byte -> latch addr byte (bit7=R/nW, bits6:0=address), checksum accumulator := byte, go to DATH.
- DATH: good byte -> latch DATA_H, accumulator += byte (mod 256), go to DATL.
- DATL: good byte -> latch DATA_L, accumulator += byte (mod 256), go to CSUM.
- CSUM: good byte -> go to HUNT.
  - If (accumulator + byte) mod 256 == 0, the frame is accepted.
  - Otherwise it is a checksum abort.
- Accepted frame, one cycle after the CSUM iDE cycle:
  - oADDR and oWDATA are updated.
  - oWE=1 if addr bit7=0, else oRE=1; exactly one strobe, for exactly one cycle.
  - oADDR and oWDATA hold until the next accepted frame.
  - For reads, the DATA bytes are still received and checksummed; oWDATA is still updated.
- Abort: a bad byte in ADDR, DATH, DATL or CSUM, a checksum mismatch, or a timeout.
  - Next state is HUNT.
  - oFRAME_ERR=1 for one cycle, the cycle after the event.
  - oERR_COUNT increments, saturating at 255.
  - oADDR and oWDATA are unchanged; no oWE/oRE.
- A SYNC_BYTE received mid-frame is ordinary data; it does not resynchronise.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on every iDE and while in HUNT.
  - In other states it increments on each cycle without iDE.
  - Abort fires in the cycle the counter reaches TIMEOUT_CYCLES. An iDE in that same cycle takes precedence (the byte is processed, the counter clears).
- oERR_COUNT updates:
  - iCLEAR_ERR=1 -> 0 next cycle.
  - If iCLEAR_ERR coincides with an abort: count=1, and oFRAME_ERR still pulses.
- Back-to-back: a new SYNC may arrive in the cycle immediately after CSUM; the decoder is in HUNT by then and accepts it.
- Throughput: one byte per cycle is sustained without loss.

Test Plan:
- Bytes A5,12,34,56,64 (12+34+56+64=0x100) -> one cycle after the last iDE: oWE=1 for 1 cycle, oADDR=7'h12, oWDATA=16'h3456; oRE=0, oERR_COUNT=0.
- Bytes A5,85,00,00,7B -> oRE=1 for 1 cycle, oADDR=7'h05, oWE=0.
- Bytes A5,12,34,56,65 -> oFRAME_ERR pulse, oERR_COUNT=1, no strobe, oADDR/oWDATA keep prior values. Then a valid frame -> accepted.
- Bytes A5,12 then a DATH byte with iPARITY_ERROR=1 -> abort, count+1. Then a separate iRETRY pulse while in HUNT -> no pulse, count unchanged.
- TIMEOUT_CYCLES=8: A5 then idle for 8 cycles -> oFRAME_ERR on schedule. Repeat with the next iDE exactly at cycle 8 -> no abort, byte accepted.
- 300 forced aborts -> oERR_COUNT saturates at 255. iCLEAR_ERR coincident with an abort -> count=1. Assert RST_N=0 mid-frame (after A5,12) -> all outputs 0, a fresh frame is accepted.
